adc_frame_packer: RTL

- Parametrised successor to the team's 8-bit/12-bit ADC-to-64-bit packer.
- Takes NUM_CH parallel ADC sample buses, selects one channel (fixed or round-robin), and packs SAMPLE_W-bit samples MSB-first into 64-bit words.
- Frames words with a one-word idle gap after each frame and emits a 40-bit TLP header once per WORDS_PER_TLP words.
- Adds config shadowing, FIFO-full detection with whole-frame drop, and a dropped-frame counter. Sits between the ADC capture pins and the DMA data/header FIFOs.

---
 rtl/adc_frame_packer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/adc_frame_packer.sv
// ADC-to-64-bit frame packer: selects one of NUM_CH sample buses, packs samples MSB-first,
// frames words with a one-word idle gap, and emits a TLP header every WORDS_PER_TLP words.
`timescale 1ns/1ps
module adc_frame_packer #(
    parameter int SAMPLE_W      = 8,
    parameter int NUM_CH        = 2,
    parameter int WORDS_PER_TLP = 16
) (
    input  logic                         InputClock,
    input  logic                         rst,
    input  logic [NUM_CH*SAMPLE_W-1:0]   ADC_in,
    input  logic [1:0]                   ChannelSelect,
    input  logic                         AutoSwitch,
    input  logic                         TestMode,
    input  logic [12:0]                  FrameLength,
    input  logic [15:0]                  BufferLengthTLPs,
    input  logic                         FifoFull,
    output logic [63:0]                  TLPData,
    output logic                         DataWriteEnable,
    output logic [39:0]                  TLPHeader,
    output logic                         HeaderWriteEnable,
    output logic                         FrameStart,
    output logic [15:0]                  DroppedFrames
);
    localparam int SPW = 64 / SAMPLE_W;
    localparam int PW  = $clog2(SPW);
    localparam int TW  = $clog2(WORDS_PER_TLP);
    localparam logic [PW-1:0] P_LAST = PW'(SPW - 1);
    localparam logic [TW-1:0] T_LAST = TW'(WORDS_PER_TLP - 1);
    localparam logic [63:0] SLOT_MASK = {{(64-SAMPLE_W){1'b0}}, {SAMPLE_W{1'b1}}};

    logic                r_run;
    logic                r_fs;
    logic [PW-1:0]       r_p;
    logic [63:0]         r_acc;
    logic [63:0]         r_data;
    logic                r_pend;
    logic                r_gap;
    logic [12:0]         r_w;
    logic [TW-1:0]       r_t;
    logic [15:0]         r_tlp;
    logic [15:0]         r_buf;
    logic [SAMPLE_W-1:0] r_tcnt;
    logic                r_drop;
    logic [15:0]         r_dropped;
    logic [12:0]         r_len_sh;
    logic [15:0]         r_buflen_sh;
    logic [1:0]          r_chsel_sh;
    logic                r_auto_sh;

    logic [1:0]          w_chsel;
    logic                w_auto;
    logic [1:0]          w_ch;
    logic [SAMPLE_W-1:0] w_adc;
    logic [SAMPLE_W-1:0] w_sample;
    int                  w_slot_shift;
    logic [63:0]         w_word;
    logic                w_dwe;
    logic                w_hwe;
    logic [39:0]         w_hdr;

    // Channel config in effect this cycle: the frame-start cycle already uses the new port values
    always_comb begin
        if (r_fs) begin
            w_chsel = ChannelSelect;
            w_auto  = AutoSwitch;
        end else begin
            w_chsel = r_chsel_sh;
            w_auto  = r_auto_sh;
        end
    end

    // Channel choice and sample source
    always_comb begin
        w_ch = 2'd0;
        if (w_auto) begin
            w_ch = 2'(int'(r_p) % NUM_CH);
        end else if (int'(w_chsel) < NUM_CH) begin
            w_ch = w_chsel;
        end else begin
            w_ch = 2'd0;
        end
        w_adc = SAMPLE_W'(ADC_in >> (int'(w_ch) * SAMPLE_W));
        if (TestMode) begin
            w_sample = r_tcnt;
        end else begin
            w_sample = w_adc;
        end
    end

    // Accumulator with the current sample merged into slot p (slot 0 is the MSB end)
    always_comb begin
        w_slot_shift = 64 - (int'(r_p) + 1) * SAMPLE_W;
        w_word = (r_acc & ~(SLOT_MASK << w_slot_shift))
               | ({{(64-SAMPLE_W){1'b0}}, w_sample} << w_slot_shift);
    end

    // Strobes are gated by FifoFull in the very cycle the word is presented
    always_comb begin
        w_dwe = r_pend & ~r_drop & ~FifoFull;
        w_hwe = w_dwe & (r_t == T_LAST);
        if (w_hwe) begin
            w_hdr = {r_buf, r_tlp, r_chsel_sh, r_auto_sh, TestMode, 4'b1111};
        end else begin
            w_hdr = 40'd0;
        end
    end

    // Packing, framing, TLP bookkeeping and drop tracking
    always_ff @(posedge InputClock or negedge rst) begin
        if (!rst) begin
            r_run       <= 1'b0;
            r_fs        <= 1'b0;
            r_p         <= '0;
            r_acc       <= 64'd0;
            r_data      <= 64'd0;
            r_pend      <= 1'b0;
            r_gap       <= 1'b0;
            r_w         <= 13'd0;
            r_t         <= '0;
            r_tlp       <= 16'd0;
            r_buf       <= 16'd0;
            r_tcnt      <= '0;
            r_drop      <= 1'b0;
            r_dropped   <= 16'd0;
            r_len_sh    <= 13'd0;
            r_buflen_sh <= 16'd0;
            r_chsel_sh  <= 2'd0;
            r_auto_sh   <= 1'b0;
        end else if (!r_run) begin
            r_run <= 1'b1;
            r_fs  <= 1'b1;
        end else begin
            r_fs   <= 1'b0;
            r_pend <= 1'b0;
            r_acc  <= w_word;
            r_tcnt <= r_tcnt + SAMPLE_W'(1);
            if (r_fs) begin
                r_len_sh    <= FrameLength;
                r_buflen_sh <= BufferLengthTLPs;
                r_chsel_sh  <= ChannelSelect;
                r_auto_sh   <= AutoSwitch;
            end
            if (r_p == P_LAST) begin
                r_p <= '0;
                if (r_gap) begin
                    r_gap <= 1'b0;
                    r_w   <= 13'd0;
                    r_fs  <= 1'b1;
                    if (r_drop) begin
                        r_drop <= 1'b0;
                        r_t    <= '0;
                    end
                end else begin
                    r_data <= w_word;
                    r_pend <= 1'b1;
                    if (r_w == r_len_sh) begin
                        r_gap <= 1'b1;
                    end else begin
                        r_w <= r_w + 13'd1;
                    end
                end
            end else begin
                r_p <= r_p + PW'(1);
            end
            if (w_dwe) begin
                if (r_t == T_LAST) begin
                    r_t <= '0;
                end else begin
                    r_t <= r_t + TW'(1);
                end
                if (w_hwe) begin
                    if (r_tlp == r_buflen_sh) begin
                        r_tlp <= 16'd0;
                        r_buf <= r_buf + 16'd1;
                    end else begin
                        r_tlp <= r_tlp + 16'd1;
                    end
                end
            end else if (r_pend && !r_drop && FifoFull) begin
                r_drop <= 1'b1;
                if (r_dropped != 16'hFFFF) begin
                    r_dropped <= r_dropped + 16'd1;
                end
            end
        end
    end

    assign TLPData           = r_data;
    assign DataWriteEnable   = w_dwe;
    assign HeaderWriteEnable = w_hwe;
    assign TLPHeader         = w_hdr;
    assign FrameStart        = r_fs;
    assign DroppedFrames     = r_dropped;
endmodule
